// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default widths, FSM encoding and port ids.
package mem_pkg;

    localparam int MEM_WORD_W = 16;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor core (master) and the memory responder (slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_WORD_W,
    parameter int ADDR_W = MEM_ADDR_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [WIDTH-1:0]  i_data;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WIDTH-1:0]  d_wdata;
    logic              d_ack;
    logic [WIDTH-1:0]  d_rdata;
    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_data, d_ack, d_rdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, i_data, d_ack, d_rdata, busy
    );

endinterface

// File: rtl/mem_arb.sv
// Fetch/data arbiter: data normally wins, but fetch is forced after STARVE data grants while it waits.
module mem_arb
    import mem_pkg::*;
#(
    parameter int STARVE = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_req,
    input  logic  d_req,
    input  logic  accept,
    output port_e grant
);

    localparam int             SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        grant = (i_req && (!d_req || starve_q == STARVE_MAX)) ? PORT_I : PORT_D;

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        starve_d = starve_q;
        if (accept) begin
            if (grant == PORT_I) begin
                starve_d = '0;
            end else if (i_req && starve_q != STARVE_MAX) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-ported word memory serving fetch and data ports with a programmable-latency one-cycle ack.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH   = MEM_WORD_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LATENCY = 1,
    parameter int STARVE  = 2
) (
    input  logic     clk,
    input  logic     reset,
    mem_responder_if.slave bus
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    port_e             port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  i_data_q, i_data_d;
    logic [WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic [WIDTH-1:0]  mem_q [2**ADDR_W];

    port_e grant;
    logic  accept;
    logic  commit;
    logic  wr_en;

    assign accept = (state_q == ST_IDLE) && (bus.i_req || bus.d_req);

    mem_arb #(.STARVE(STARVE)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req  (bus.i_req),
        .d_req  (bus.d_req),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    port_d  = grant;
                    addr_d  = (grant == PORT_I) ? bus.i_addr : bus.d_addr;
                    we_d    = (grant == PORT_D) && bus.d_we;
                    wdata_d = bus.d_wdata;
                    cnt_d   = LAT;
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The *_d transaction fields are valid on the entering edge for both zero and nonzero latency.
        commit = (state_d == ST_ACK) && (state_q != ST_ACK);
        wr_en  = commit && reset && (port_d == PORT_D) && we_d;
        if (commit) begin
            if (port_d == PORT_I) begin
                i_data_d = mem_q[addr_d];
            end else if (!we_d) begin
                d_rdata_d = mem_q[addr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // NOTE: the array is deliberately not reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_d] <= wdata_d;
        end
    end

    assign bus.i_ack   = (state_q == ST_ACK) && (port_q == PORT_I);
    assign bus.d_ack   = (state_q == ST_ACK) && (port_q == PORT_D);
    assign bus.i_data  = i_data_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at LATENCY=1 and one at LATENCY=0.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct {
        port_e       port;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        i_req_s[2];
    logic        d_req_s[2];
    logic        d_we_s[2];
    logic [15:0] i_addr_s[2];
    logic [15:0] d_addr_s[2];
    logic [15:0] d_wdata_s[2];
    logic        i_ack_w[2];
    logic        d_ack_w[2];

    mem_responder_if #(.WIDTH(16), .ADDR_W(16)) if0 ();
    mem_responder_if #(.WIDTH(16), .ADDR_W(16)) if1 ();

    assign if0.i_req   = i_req_s[0];
    assign if0.i_addr  = i_addr_s[0];
    assign if0.d_req   = d_req_s[0];
    assign if0.d_we    = d_we_s[0];
    assign if0.d_addr  = d_addr_s[0];
    assign if0.d_wdata = d_wdata_s[0];
    assign if1.i_req   = i_req_s[1];
    assign if1.i_addr  = i_addr_s[1];
    assign if1.d_req   = d_req_s[1];
    assign if1.d_we    = d_we_s[1];
    assign if1.d_addr  = d_addr_s[1];
    assign if1.d_wdata = d_wdata_s[1];
    assign i_ack_w[0]  = if0.i_ack;
    assign d_ack_w[0]  = if0.d_ack;
    assign i_ack_w[1]  = if1.i_ack;
    assign d_ack_w[1]  = if1.d_ack;

    mem_responder #(.WIDTH(16), .ADDR_W(16), .LATENCY(0), .STARVE(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    mem_responder #(.WIDTH(16), .ADDR_W(16), .LATENCY(1), .STARVE(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int u, input port_e p, input logic [15:0] data);
        exp_t e;
        e.port = p;
        e.data = data;
        if (u == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    // Monitor: pops the oldest expectation whenever an instance raises an ack.
    task automatic mon(input int u);
        logic  ia, da;
        logic [15:0] act;
        int    qsz;
        exp_t  e;
        string tag;
        ia  = i_ack_w[u];
        da  = d_ack_w[u];
        tag = (u == 1) ? "dut1" : "dut0";
        if (ia || da) begin
            check({tag, "_ack_overlap"}, {31'b0, ia & da}, 32'd0);
            qsz = (u == 1) ? q1.size() : q0.size();
            if (qsz == 0) begin
                check({tag, "_unexpected_ack"}, qsz, 32'd1);
            end else begin
                e   = (u == 1) ? q1.pop_front() : q0.pop_front();
                act = (u == 1) ? (ia ? if1.i_data : if1.d_rdata) : (ia ? if0.i_data : if0.d_rdata);
                check({tag, "_ack_port"}, 32'(ia ? PORT_I : PORT_D), 32'(e.port));
                check({tag, "_ack_data"}, {16'b0, act}, {16'b0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0);
            mon(1);
        end
    end

    // One transaction; called just after a posedge with the instance idle, returns just after the
    // edge that ends the ack cycle.
    task automatic txn(input int u, input port_e p, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_data,
                       input int exp_lat, input string name);
        int n = 0;
        bit got = 0;
        if (p == PORT_I) begin
            i_addr_s[u] = addr;
            i_req_s[u]  = 1'b1;
        end else begin
            d_we_s[u]    = we;
            d_addr_s[u]  = addr;
            d_wdata_s[u] = wdata;
            d_req_s[u]   = 1'b1;
        end
        push_exp(u, p, exp_data);
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = (p == PORT_I) ? i_ack_w[u] : d_ack_w[u];
        end
        check({name, "_latency"}, n, exp_lat);
        @(posedge clk); #1;
        i_req_s[u] = 1'b0;
        d_req_s[u] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        int n;
        int gap;
        bit got;

        for (int u = 0; u < 2; u++) begin
            i_req_s[u] = 1'b0; d_req_s[u] = 1'b0; d_we_s[u] = 1'b0;
            i_addr_s[u] = '0; d_addr_s[u] = '0; d_wdata_s[u] = '0;
        end
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {29'b0, if1.i_ack, if1.d_ack, if1.busy}, 32'd0);
        check("rst_i_data", {16'b0, if1.i_data}, 32'd0);
        check("rst_d_rdata", {16'b0, if1.d_rdata}, 32'd0);
        check("rst_flags_dut0", {29'b0, if0.i_ack, if0.d_ack, if0.busy}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Preload through the store path, then a load so d_rdata is nonzero before the reset test.
        txn(1, PORT_D, 1'b1, 16'h0040, 16'h5A5A, 16'h0000, 2, "pre_st40");
        txn(1, PORT_D, 1'b1, 16'h0003, 16'hA1B2, 16'h0000, 2, "pre_st03");
        txn(1, PORT_D, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 2, "pre_ld40");

        // Test 1: reset in the middle of WAIT of a store; no ack, store dropped.
        d_we_s[1] = 1'b1; d_addr_s[1] = 16'h0040; d_wdata_s[1] = 16'h1234; d_req_s[1] = 1'b1;
        @(posedge clk); #2;
        check("t1_busy_in_wait", {31'b0, if1.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t1_rst_flags", {29'b0, if1.i_ack, if1.d_ack, if1.busy}, 32'd0);
        check("t1_rst_d_rdata", {16'b0, if1.d_rdata}, 32'd0);
        d_req_s[1] = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("t1_idle_after_rst", {31'b0, if1.busy}, 32'd0);
        txn(1, PORT_D, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 2, "t1_load");

        // Test 2: fetch with LATENCY=1.
        txn(1, PORT_I, 1'b0, 16'h0003, 16'h0000, 16'hA1B2, 2, "t2_fetch");

        // Test 3: store leaves d_rdata alone; following load sees the stored value.
        txn(1, PORT_D, 1'b1, 16'h0010, 16'hBEEF, 16'h5A5A, 2, "t3_store");
        txn(1, PORT_D, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2, "t3_load");

        // Test 4: both ports held high; grants must run D,D,I,D,D,I.
        d_we_s[1] = 1'b0; d_addr_s[1] = 16'h0010; i_addr_s[1] = 16'h0003;
        push_exp(1, PORT_D, 16'hBEEF);
        push_exp(1, PORT_D, 16'hBEEF);
        push_exp(1, PORT_I, 16'hA1B2);
        push_exp(1, PORT_D, 16'hBEEF);
        push_exp(1, PORT_D, 16'hBEEF);
        push_exp(1, PORT_I, 16'hA1B2);
        i_req_s[1] = 1'b1; d_req_s[1] = 1'b1;
        acks = 0; n = 0;
        while (acks < 6 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (i_ack_w[1] || d_ack_w[1]) acks++;
        end
        i_req_s[1] = 1'b0; d_req_s[1] = 1'b0;
        check("t4_ack_count", acks, 32'd6);
        check("t4_cycles", n, 32'd17);
        @(posedge clk); #1;

        // Test 6: data request dropped during WAIT still completes once.
        d_we_s[1] = 1'b0; d_addr_s[1] = 16'h0040; d_req_s[1] = 1'b1;
        push_exp(1, PORT_D, 16'h5A5A);
        @(posedge clk); #1;
        d_req_s[1] = 1'b0;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = d_ack_w[1];
        end
        check("t6_ack_seen", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        check("t6_ack_single", {31'b0, if1.d_ack}, 32'd0);
        check("t6_busy_fall", {31'b0, if1.busy}, 32'd0);
        @(posedge clk); #1;
        check("t6_stays_idle", {31'b0, if1.busy}, 32'd0);

        // Test 5: LATENCY=0, back-to-back loads at the top and bottom of the address range.
        txn(0, PORT_D, 1'b1, 16'hFFFF, 16'h1357, 16'h0000, 1, "t5_st_hi");
        txn(0, PORT_D, 1'b1, 16'h0000, 16'h2468, 16'h0000, 1, "t5_st_lo");
        push_exp(0, PORT_D, 16'h1357);
        push_exp(0, PORT_D, 16'h2468);
        d_we_s[0] = 1'b0; d_addr_s[0] = 16'hFFFF; d_req_s[0] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = d_ack_w[0];
        end
        check("t5_first_latency", n, 32'd1);
        d_addr_s[0] = 16'h0000;
        got = 0; gap = 0;
        while (!got && gap < 20) begin
            @(posedge clk); #1;
            gap++;
            got = d_ack_w[0];
        end
        d_req_s[0] = 1'b0;
        check("t5_ack_spacing", gap, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("dut0_queue_drained", q0.size(), 32'd0);
        check("dut1_queue_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
